// File: rtl/key_press_sequencer_if.sv
// Key-code handshake between the frequency-to-key mapper (master) and the
// press sequencer (slave). The mapper holds keyIn/keyValid until keyReady.
interface key_press_sequencer_if;
  logic [4:0] keyIn;
  logic       keyValid;
  logic       keyReady;

  modport master (
    output keyIn,
    output keyValid,
    input  keyReady
  );

  modport slave (
    input  keyIn,
    input  keyValid,
    output keyReady
  );
endinterface

// File: rtl/key_press_sequencer.sv
// Key press sequencer: turns each accepted 5-bit key code into one timed
// solenoid press on the 24-finger actuator bank, followed by a release gap
// during which every solenoid is off. A stop request cuts the press short
// and (re)starts the gap.
module key_press_sequencer #(
  parameter int unsigned PRESS_CYCLES = 6500000,
  parameter int unsigned GAP_CYCLES   = 3250000,
  parameter int unsigned CNT_W        = 24
) (
  input  logic                        clkIn,
  input  logic                        rstN,
  key_press_sequencer_if.slave        keyBus,
  input  logic                        stopIn,
  output logic [23:0]                 solenoidOut,
  output logic                        busy,
  output logic                        badKey
);

  typedef enum logic [1:0] {
    IDLE,
    PRESS,
    GAP
  } state_t;

  // Counter reload values; the counter runs from LOAD down to 0 inclusive,
  // so each phase lasts exactly its cycle count.
  localparam logic [CNT_W-1:0] PRESS_LOAD = CNT_W'(PRESS_CYCLES - 1);
  localparam logic [CNT_W-1:0] GAP_LOAD   = CNT_W'(GAP_CYCLES - 1);

  state_t           r_state;
  logic [CNT_W-1:0] r_count;
  logic             r_started;
  logic [23:0]      r_solenoid;
  logic             r_busy;
  logic             r_badKey;

  logic             w_accept;
  logic             w_legal;
  logic [4:0]       w_index;
  logic [23:0]      w_onehot;

  // Upper bank keys sit 12 positions above the lower bank ones.
  assign w_legal  = (keyBus.keyIn[3:0] <= 4'd11);
  assign w_index  = keyBus.keyIn[4] ? (5'd12 + {1'b0, keyBus.keyIn[3:0]})
                                    : {1'b0, keyBus.keyIn[3:0]};
  assign w_onehot = 24'd1 << w_index;

  // Ready only once out of reset, only in IDLE, and never while a stop is
  // being requested so an abort cannot race a fresh accept.
  assign keyBus.keyReady = r_started && (r_state == IDLE) && !stopIn;
  assign w_accept        = keyBus.keyValid && keyBus.keyReady;

  // Marks the first clock edge after reset release; IDLE alone is not
  // enough because keyReady must stay low while reset is held.
  always_ff @(posedge clkIn or negedge rstN) begin
    if (!rstN) begin
      r_started <= 1'b0;
    end else begin
      r_started <= 1'b1;
    end
  end

  // Press/gap sequencing with registered outputs; reset clears the drive
  // immediately so a press in flight is dropped at once.
  always_ff @(posedge clkIn or negedge rstN) begin
    if (!rstN) begin
      r_state    <= IDLE;
      r_count    <= '0;
      r_solenoid <= '0;
      r_busy     <= 1'b0;
      r_badKey   <= 1'b0;
    end else begin
      r_badKey <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_accept) begin
            if (w_legal) begin
              r_state    <= PRESS;
              r_solenoid <= w_onehot;
              r_count    <= PRESS_LOAD;
              r_busy     <= 1'b1;
            end else begin
              r_badKey <= 1'b1;
            end
          end
        end
        PRESS: begin
          if (stopIn || (r_count == '0)) begin
            r_state    <= GAP;
            r_solenoid <= '0;
            r_count    <= GAP_LOAD;
          end else begin
            r_count <= r_count - 1'b1;
          end
        end
        GAP: begin
          if (stopIn) begin
            r_count <= GAP_LOAD;
          end else if (r_count == '0) begin
            r_state <= IDLE;
            r_busy  <= 1'b0;
          end else begin
            r_count <= r_count - 1'b1;
          end
        end
        default: begin
          r_state    <= IDLE;
          r_count    <= '0;
          r_solenoid <= '0;
          r_busy     <= 1'b0;
        end
      endcase
    end
  end

  assign solenoidOut = r_solenoid;
  assign busy        = r_busy;
  assign badKey      = r_badKey;

endmodule

// File: tb/tb_key_press_sequencer.sv
// Scoreboard bench for key_press_sequencer with short press/gap timing.
// Stimulus pushes the expected press or badKey event; a monitor pops and
// compares whenever the DUT starts a press or pulses badKey.
module tb_key_press_sequencer;

  localparam int PRESS = 4;
  localparam int GAP   = 2;

  typedef struct {
    logic        isBad;
    logic [23:0] sol;
    int          len;
  } exp_t;

  logic        clkIn;
  logic        rstN;
  logic        stopIn;
  logic [23:0] solenoidOut;
  logic        busy;
  logic        badKey;

  int          assertCount;
  int          failCount;
  exp_t        expQ[$];

  logic [23:0] monPrev;
  int          monRun;
  int          monLen;
  exp_t        monExp;

  key_press_sequencer_if bus ();

  key_press_sequencer #(
    .PRESS_CYCLES(PRESS),
    .GAP_CYCLES  (GAP),
    .CNT_W       (24)
  ) dut (
    .clkIn      (clkIn),
    .rstN       (rstN),
    .keyBus     (bus),
    .stopIn     (stopIn),
    .solenoidOut(solenoidOut),
    .busy       (busy),
    .badKey     (badKey)
  );

  initial clkIn = 1'b0;
  always #5 clkIn = ~clkIn;

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    assertCount++;
    if (actual !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  task automatic failEvent(input string name);
    assertCount++;
    failCount++;
    $display("[TB] FAIL %s: got an event, expected none", name);
  endtask

  // Bounded wait for keyReady, sampled on the falling edge.
  task automatic waitReady();
    int n;
    n = 0;
    while (!bus.keyReady && n < 100) begin
      @(negedge clkIn);
      n++;
    end
    if (!bus.keyReady) checkOutput("readyTimeout", 0, 1);
  endtask

  // From just after an edge, count falling edges until keyReady and how many
  // of them saw busy high.
  task automatic measureReady(output int n, output int busyCnt);
    n = 0;
    busyCnt = 0;
    while (n < 100) begin
      @(negedge clkIn);
      n++;
      if (busy) busyCnt++;
      if (bus.keyReady) break;
    end
    if (!bus.keyReady) checkOutput("measureTimeout", 0, 1);
  endtask

  // Offer one key for exactly one accept edge; returns #1 after that edge.
  task automatic applyStimulus(input logic [4:0] key, input logic isBad,
                               input logic [23:0] sol, input int len);
    exp_t e;
    waitReady();
    @(negedge clkIn);
    e.isBad = isBad;
    e.sol   = sol;
    e.len   = len;
    expQ.push_back(e);
    bus.keyIn    = key;
    bus.keyValid = 1'b1;
    @(posedge clkIn);
    #1;
    bus.keyValid = 1'b0;
  endtask

  // Monitor: pop on every press start and badKey pulse, then follow the
  // press to check it holds steady and lasts the expected number of cycles.
  initial begin
    monPrev = '0;
    monRun  = 0;
    monLen  = 0;
    forever begin
      @(negedge clkIn);
      if (badKey === 1'b1) begin
        if (expQ.size() == 0) begin
          failEvent("unexpectedBadKey");
        end else begin
          monExp = expQ.pop_front();
          checkOutput("badKeyEvent", 32'(monExp.isBad), 1);
        end
      end
      if (solenoidOut !== 24'd0 && monPrev === 24'd0) begin
        if (expQ.size() == 0) begin
          failEvent("unexpectedPress");
          monLen = 0;
        end else begin
          monExp = expQ.pop_front();
          checkOutput("pressNotBad", 32'(monExp.isBad), 0);
          checkOutput("pressSolenoid", 32'(solenoidOut), 32'(monExp.sol));
          monLen = monExp.len;
        end
        monRun = 1;
      end else if (solenoidOut !== 24'd0) begin
        monRun++;
        checkOutput("pressHold", 32'(solenoidOut), 32'(monPrev));
      end else if (monPrev !== 24'd0 && monLen != 0) begin
        checkOutput("pressLength", monRun, monLen);
      end
      monPrev = solenoidOut;
    end
  end

  initial begin
    int n;
    int busyCnt;
    exp_t e;
    assertCount  = 0;
    failCount    = 0;
    rstN         = 1'b0;
    stopIn       = 1'b0;
    bus.keyIn    = 5'b10001;
    bus.keyValid = 1'b1;

    // Reset held with valid asserted: nothing may be accepted.
    repeat (3) begin
      @(negedge clkIn);
      checkOutput("resetSolenoid", 32'(solenoidOut), 0);
      checkOutput("resetBusy", 32'(busy), 0);
      checkOutput("resetReady", 32'(bus.keyReady), 0);
    end
    @(posedge clkIn);
    #1;
    rstN = 1'b1;
    bus.keyValid = 1'b0;
    @(negedge clkIn);
    checkOutput("readyBeforeFirstEdge", 32'(bus.keyReady), 0);
    @(negedge clkIn);
    checkOutput("readyAfterFirstEdge", 32'(bus.keyReady), 1);

    // Legal press on bit 13: ready again 7 edges later, busy 6 cycles.
    applyStimulus(5'b10001, 1'b0, 24'h002000, PRESS);
    measureReady(n, busyCnt);
    checkOutput("legalReadyLatency", n, 7);
    checkOutput("legalBusyCycles", busyCnt, 6);

    // Valid held 20 cycles on key 0: accepts at edges 1, 8 and 15.
    waitReady();
    @(negedge clkIn);
    e.isBad = 1'b0;
    e.sol   = 24'h000001;
    e.len   = PRESS;
    repeat (3) expQ.push_back(e);
    bus.keyIn    = 5'b00000;
    bus.keyValid = 1'b1;
    repeat (20) @(posedge clkIn);
    #1;
    bus.keyValid = 1'b0;
    waitReady();
    checkOutput("heldQueueDrained", expQ.size(), 0);

    // Two illegal codes back to back: two badKey pulses, ready stays high.
    waitReady();
    @(negedge clkIn);
    e.isBad = 1'b1;
    e.sol   = 24'd0;
    e.len   = 0;
    expQ.push_back(e);
    bus.keyIn    = 5'b01100;
    bus.keyValid = 1'b1;
    @(posedge clkIn);
    #1;
    expQ.push_back(e);
    bus.keyIn = 5'b11111;
    @(negedge clkIn);
    checkOutput("illegalReady1", 32'(bus.keyReady), 1);
    checkOutput("illegalSolenoid", 32'(solenoidOut), 0);
    @(posedge clkIn);
    #1;
    bus.keyValid = 1'b0;
    @(negedge clkIn);
    checkOutput("illegalReady2", 32'(bus.keyReady), 1);
    checkOutput("illegalBusy", 32'(busy), 0);

    // Stop in IDLE blocks acceptance of a valid key.
    @(negedge clkIn);
    stopIn       = 1'b1;
    bus.keyIn    = 5'b00011;
    bus.keyValid = 1'b1;
    #1;
    checkOutput("stopBlocksReady", 32'(bus.keyReady), 0);
    @(posedge clkIn);
    #1;
    stopIn       = 1'b0;
    bus.keyValid = 1'b0;
    @(negedge clkIn);
    checkOutput("stopIdleBusy", 32'(busy), 0);

    // Stop on the 2nd press cycle of bit 23: 2 press cycles, then 2 gap
    // cycles (total busy 4).
    applyStimulus(5'b11011, 1'b0, 24'h800000, 2);
    @(posedge clkIn);
    #1;
    stopIn = 1'b1;
    @(posedge clkIn);
    #1;
    stopIn = 1'b0;
    measureReady(n, busyCnt);
    checkOutput("stopPressReadyLatency", n, 3);
    checkOutput("stopPressBusyTail", busyCnt, 2);

    // Stop during the gap restarts it.
    applyStimulus(5'b00111, 1'b0, 24'h000080, PRESS);
    repeat (4) @(posedge clkIn);
    #1;
    stopIn = 1'b1;
    @(posedge clkIn);
    #1;
    stopIn = 1'b0;
    measureReady(n, busyCnt);
    checkOutput("stopGapReadyLatency", n, 3);
    checkOutput("stopGapBusyTail", busyCnt, 2);

    // Async reset mid-press drops the solenoid before the next edge.
    applyStimulus(5'b00101, 1'b0, 24'h000020, 0);
    @(posedge clkIn);
    #3;
    rstN = 1'b0;
    #1;
    checkOutput("asyncResetSolenoid", 32'(solenoidOut), 0);
    checkOutput("asyncResetBusy", 32'(busy), 0);
    checkOutput("asyncResetReady", 32'(bus.keyReady), 0);
    @(posedge clkIn);
    #1;
    rstN = 1'b1;
    @(negedge clkIn);
    @(negedge clkIn);
    checkOutput("postResetReady", 32'(bus.keyReady), 1);
    repeat (3) begin
      @(negedge clkIn);
      checkOutput("postResetSolenoid", 32'(solenoidOut), 0);
      checkOutput("postResetBusy", 32'(busy), 0);
    end

    repeat (3) @(negedge clkIn);
    checkOutput("scoreboardEmpty", expQ.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule

// File: doc/key_press_sequencer.md
Name: key_press_sequencer

Overview:
- Downstream consumer of the 5-bit key code produced by the frequency-to-key mapper.
- Turns each accepted key code into one timed solenoid press on the robot's 24-finger actuator bank, followed by a mandatory release gap.
- Accepts codes over a valid/ready handshake so the note-detection front end can stall while a press is in progress.

Parameters:
- PRESS_CYCLES, 6500000: clock cycles a solenoid is held on per press (100 ms at 65 MHz); legal range is 1 or more.
- GAP_CYCLES, 3250000: clock cycles with all solenoids off after every press or stop; legal range is 1 or more.
- CNT_W, 24: counter width; must hold max(PRESS_CYCLES, GAP_CYCLES)-1.

Ports:
- clkIn  input  1  system clock.
- rstN  input  1  reset, asynchronous, active-low.
- keyIn  input  5  key code. Bit4 selects the bank (0 = lower, 1 = upper). Bits[3:0] give the semitone, 0..11.
- keyValid  input  1  keyIn is valid this cycle.
- keyReady  output  1  block can accept a key this cycle.
- stopIn  input  1  synchronous abort of the current press.
- solenoidOut  output  24  one-hot solenoid drive; index = bit4*12 + bits[3:0].
- busy  output  1  high in PRESS or GAP.
- badKey  output  1  one-cycle pulse when an illegal code (semitone 12..15) is accepted.

Behaviour:
- Reset (rstN low, asynchronous): state = IDLE, counter = 0, solenoidOut = 0, busy = 0, badKey = 0. keyReady is 0 while rstN is low and 1 from the first clkIn edge after release.
- States are IDLE, PRESS and GAP. All outputs are registered, except keyReady, which is decoded combinationally from state (high only in IDLE).
- Accept: keyValid && keyReady at a clock edge. keyIn is captured at that edge. keyValid while keyReady is low is ignored (no capture, no buffering); the upstream block holds it.
- IDLE, legal accept (bits[3:0] <= 11): next state PRESS. solenoidOut is set to the one-hot index. Counter loads PRESS_CYCLES-1.
- IDLE, illegal accept: state stays IDLE, solenoidOut stays 0, badKey = 1 for exactly one cycle, keyReady stays high. Back-to-back illegal codes pulse badKey on consecutive cycles.
- PRESS: counter decrements each cycle. At counter = 0, next state is GAP, solenoidOut = 0 and counter loads GAP_CYCLES-1.
  - The solenoid is therefore high for exactly PRESS_CYCLES cycles, starting the cycle after accept.
- GAP: counter decrements. At counter = 0, next state is IDLE.
  - For a key accepted at edge k, keyReady rises again at edge k+1+PRESS_CYCLES+GAP_CYCLES.
- A repeated identical key receives the full press and gap. Same-key requests are not merged.
- stopIn in PRESS: solenoidOut = 0 at the next edge, state becomes GAP and counter loads GAP_CYCLES-1. This takes priority over the counter reaching 0 on the same edge.
- stopIn in GAP: the gap restarts (counter reloads GAP_CYCLES-1).
- stopIn in IDLE: no effect. stopIn blocks acceptance: keyReady is forced low while stopIn is high.
- Invariant: at most one bit of solenoidOut is ever set, and never outside PRESS.
- rstN asserted mid-press: solenoidOut clears immediately (asynchronously). Any in-flight key is discarded.
- The counter never wraps. It is only loaded on state entry and decremented while non-zero.

Test Plan (PRESS_CYCLES=4, GAP_CYCLES=2):
- Reset: hold rstN low for 3 cycles with keyValid=1 -> solenoidOut = 0, busy = 0, no accept. keyReady = 1 on the first edge after release.
- Legal press: keyIn = 5'b10001, keyValid for 1 cycle at edge k -> solenoidOut = 24'h002000 (bit 13) on edges k+1..k+4, then 0. busy is high through k+6. keyReady is high again at k+7.
- Held valid: keyIn = 5'b00000 with keyValid held 20 cycles -> a press on bit 0 every 7 cycles (4 on, 2 gap, 1 accept). solenoidOut is never high for more than 4 consecutive cycles.
- Illegal code: keyIn = 5'b01100 -> badKey = 1 for one cycle, solenoidOut stays 0, keyReady stays 1. keyIn = 5'b11111 on the next cycle -> second badKey pulse.
- Stop: accept 5'b11011 (bit 23), then pulse stopIn on the 2nd press cycle -> bit 23 drops on the next edge, then 2 gap cycles, then keyReady = 1. Total busy time is 4 cycles.
- Async reset mid-press: drop rstN between clock edges during PRESS -> solenoidOut = 0 before the next edge. After release the state is IDLE with no residual press.
